// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared definitions for the instruction fetch stage and the
//                decoder: FSM state encoding, instruction geometry constants
//                and the opcode-to-length decode.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } fetch_state_t;

  localparam int MAX_LEN = 3;   // longest instruction, in bytes
  localparam int INSTR_W = 24;  // assembled instruction width

  // Instruction length from the opcode's two top bits:
  // 00 -> 1 byte, 01 -> 2 bytes, 1x -> 3 bytes.
  function automatic logic [1:0] decode_len(input logic [7:0] opcode);
    logic [1:0] len;
    casez (opcode)
      8'b00??????: len = 2'd1;
      8'b01??????: len = 2'd2;
      default:     len = 2'd3;
    endcase
    return len;
  endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage in front of a byte-wide ROM with a
//                one-cycle registered response. Reads 1..3 bytes per
//                instruction (length from opcode[7:6]), assembles them and
//                offers the result to the decoder with a valid/accept
//                handshake. A redirect from execute abandons the current
//                fetch and restarts at a new PC.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          clock, synchronous active-high reset
//    rom_read          one-cycle read strobe, at most one read outstanding
//    rom_address       byte address, valid while rom_read=1
//    rom_ready         ROM data valid (sampled only while waiting for it)
//    rom_data          ROM byte
//    instr_valid       assembled instruction available
//    instr             {byte2, byte1, opcode}, unused bytes zero
//    instr_len         instruction length in bytes (1..3)
//    instr_pc          address of the opcode byte
//    instr_accept      decoder consumes the instruction
//    redirect_valid    load redirect_addr as new PC, drop current fetch
//    redirect_addr     redirect target
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int size_addr    = 8,
  parameter int reset_vector = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 rom_read,
  output logic [size_addr-1:0] rom_address,
  input  logic                 rom_ready,
  input  logic [7:0]           rom_data,
  output logic                 instr_valid,
  output logic [INSTR_W-1:0]   instr,
  output logic [1:0]           instr_len,
  output logic [size_addr-1:0] instr_pc,
  input  logic                 instr_accept,
  input  logic                 redirect_valid,
  input  logic [size_addr-1:0] redirect_addr
);

  localparam logic [size_addr-1:0] c_reset_pc = size_addr'(reset_vector);

  fetch_state_t         r_state;
  logic [size_addr-1:0] r_pc;
  logic [1:0]           r_cnt;

  logic [1:0]           w_len;
  logic                 w_last;
  logic [size_addr-1:0] w_next_byte_addr;
  logic [size_addr-1:0] w_next_pc;

  // While the opcode itself is arriving the latched length is stale, so the
  // length is taken straight from the incoming byte.
  assign w_len  = (r_cnt == 2'd0) ? decode_len(rom_data) : instr_len;
  assign w_last = ((r_cnt + 2'd1) == w_len) || (r_cnt == 2'(MAX_LEN - 1));

  // Address arithmetic is size_addr bits wide, so it wraps naturally.
  assign w_next_byte_addr = r_pc + size_addr'(r_cnt) + size_addr'(1);
  assign w_next_pc        = r_pc + size_addr'(instr_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= c_reset_pc;
      r_cnt       <= 2'd0;
      rom_read    <= 1'b0;
      rom_address <= c_reset_pc;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_len   <= 2'd0;
      instr_pc    <= c_reset_pc;
    end else if (redirect_valid) begin
      // Redirect overrides everything, including an accept in S_OUT: the
      // handshake still completes but the PC comes from the redirect.
      r_state     <= S_REQ;
      r_pc        <= redirect_addr;
      r_cnt       <= 2'd0;
      rom_read    <= 1'b1;
      rom_address <= redirect_addr;
      instr_valid <= 1'b0;
      instr       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state     <= S_REQ;
          rom_read    <= 1'b1;
          rom_address <= r_pc + size_addr'(r_cnt);
        end

        S_REQ: begin
          r_state  <= S_WAIT;
          rom_read <= 1'b0;
        end

        S_WAIT: begin
          rom_read <= 1'b0;
          if (rom_ready) begin
            case (r_cnt)
              2'd0: begin
                // Opcode starts a new instruction: clear the upper slots.
                instr     <= {16'h0000, rom_data};
                instr_len <= w_len;
                instr_pc  <= r_pc;
              end
              2'd1:    instr[15:8]  <= rom_data;
              default: instr[23:16] <= rom_data;
            endcase
            if (w_last) begin
              r_state     <= S_OUT;
              instr_valid <= 1'b1;
            end else begin
              r_cnt       <= r_cnt + 2'd1;
              r_state     <= S_REQ;
              rom_read    <= 1'b1;
              rom_address <= w_next_byte_addr;
            end
          end
        end

        S_OUT: begin
          if (instr_accept) begin
            r_pc        <= w_next_pc;
            r_cnt       <= 2'd0;
            instr_valid <= 1'b0;
            r_state     <= S_REQ;
            rom_read    <= 1'b1;
            rom_address <= w_next_pc;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          rom_read <= 1'b0;
        end
      endcase
    end
  end

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit with a byte ROM
//                model that answers one cycle after each read strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_read;
  logic [7:0]  rom_address;
  logic        rom_ready;
  logic [7:0]  rom_data;
  logic        instr_valid;
  logic [23:0] instr;
  logic [1:0]  instr_len;
  logic [7:0]  instr_pc;
  logic        instr_accept;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;

  int n_checks = 0;
  int n_errors = 0;
  int hs_count = 0;
  logic [7:0] rd_q[$];
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  fetch_unit #(
    .size_addr    (8),
    .reset_vector (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_read       (rom_read),
    .rom_address    (rom_address),
    .rom_ready      (rom_ready),
    .rom_data       (rom_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_len      (instr_len),
    .instr_pc       (instr_pc),
    .instr_accept   (instr_accept),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr)
  );

  // ROM: registered response one cycle after the read strobe
  initial begin
    rom_ready = 1'b0;
    rom_data  = 8'h00;
  end
  always @(posedge clk) begin
    rom_ready <= rom_read;
    rom_data  <= mem[rom_address];
  end

  // Handshake and read-address monitor
  always @(posedge clk) begin
    if (!rst) begin
      if (instr_valid && instr_accept) hs_count <= hs_count + 1;
      if (rom_read) rd_q.push_back(rom_address);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Count falling edges until instr_valid is seen (bounded), check latency
  // and the delivered instruction.
  task automatic expect_instr(input string tag, input int lat,
                              input logic [23:0] e_instr, input logic [1:0] e_len,
                              input logic [7:0] e_pc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 50);
    check({tag, "_lat"},   32'(n), 32'(lat));
    check({tag, "_instr"}, 32'(instr), 32'(e_instr));
    check({tag, "_len"},   32'(instr_len), 32'(e_len));
    check({tag, "_pc"},    32'(instr_pc), 32'(e_pc));
  endtask

  task automatic pulse_redirect(input logic [7:0] addr);
    redirect_valid = 1'b1;
    redirect_addr  = addr;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    int hs0, rd0, n;
    logic [23:0] held;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h05; mem[8'h01] = 8'h41; mem[8'h02] = 8'h22;
    mem[8'h10] = 8'h80; mem[8'h11] = 8'hAA; mem[8'h12] = 8'hBB;
    mem[8'h13] = 8'hC0; mem[8'h14] = 8'h11; mem[8'h15] = 8'h22;
    mem[8'h40] = 8'h01;
    mem[8'h20] = 8'h03;
    mem[8'hFF] = 8'h41;

    rst = 1'b1; instr_accept = 1'b1;
    redirect_valid = 1'b0; redirect_addr = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_read",  32'(rom_read), 0);
    check("rst_addr",  32'(rom_address), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_len",   32'(instr_len), 0);
    check("rst_pc",    32'(instr_pc), 0);

    // Reset release, accept tied high: 1-byte at +3, 2-byte at +5 more
    rst = 1'b0;
    expect_instr("t1a", 3, 24'h000005, 2'd1, 8'h00);
    expect_instr("t1b", 5, 24'h002241, 2'd2, 8'h01);
    instr_accept = 1'b0;

    // 3-byte instruction at 0x10, then hold it without accept
    pulse_redirect(8'h10);
    expect_instr("t2", 6, 24'hBBAA80, 2'd3, 8'h10);
    rd0 = rd_q.size();
    held = instr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", 32'(instr_valid), 1);
      check("t2_hold_instr", 32'(instr), 32'(held));
    end
    check("t2_no_reads", 32'(rd_q.size()), 32'(rd0));

    // Accept, then redirect while waiting for byte 2 of the 3-byte at 0x13
    instr_accept = 1'b1;
    @(negedge clk);
    instr_accept = 1'b0;
    check("t3_next_addr", 32'(rom_address), 32'h13);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rom_read && rom_address == 8'h14) && n < 20);
    check("t3_byte2_read", 32'(n < 20), 1);
    @(negedge clk);
    pulse_redirect(8'h40);
    check("t3_redir_read", 32'(rom_read), 1);
    check("t3_redir_addr", 32'(rom_address), 32'h40);
    expect_instr("t3", 2, 24'h000001, 2'd1, 8'h40);

    // Accept and redirect together in S_OUT
    hs0 = hs_count;
    instr_accept = 1'b1;
    pulse_redirect(8'h20);
    instr_accept = 1'b0;
    check("t4_handshakes", 32'(hs_count - hs0), 1);
    check("t4_valid",      32'(instr_valid), 0);
    check("t4_read",       32'(rom_read), 1);
    check("t4_addr",       32'(rom_address), 32'h20);
    expect_instr("t4", 2, 24'h000003, 2'd1, 8'h20);

    // 2-byte instruction straddling 0xFF -> 0x00
    rd_q.delete();
    pulse_redirect(8'hFF);
    expect_instr("t5", 4, 24'h000541, 2'd2, 8'hFF);
    check("t5_nreads", 32'(rd_q.size()), 2);
    if (rd_q.size() == 2) begin
      check("t5_rd0", 32'(rd_q[0]), 32'hFF);
      check("t5_rd1", 32'(rd_q[1]), 32'h00);
    end
    instr_accept = 1'b1;
    @(negedge clk);
    instr_accept = 1'b0;
    check("t5_next_read", 32'(rom_read), 1);
    check("t5_next_addr", 32'(rom_address), 32'h01);

    // Reset while in S_WAIT with the ROM response present
    @(negedge clk);
    check("t6_rom_ready", 32'(rom_ready), 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_valid", 32'(instr_valid), 0);
    check("t6_read",  32'(rom_read), 0);
    check("t6_addr",  32'(rom_address), 0);
    check("t6_pc",    32'(instr_pc), 0);
    rst = 1'b0;
    instr_accept = 1'b1;
    expect_instr("t6", 3, 24'h000005, 2'd1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_fetch_unit
`default_nettype wire
